// File: rtl/regbank_arb_pkg.sv
// Shared types and default parameters for the configuration register bank arbiter.
// Holds the FSM state encoding and the pointer-width helper used by top and picker.
package regbank_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_NUM_REQ  = 2;
  localparam int DEF_LOCK_MAX = 4;

  // A single requester still needs a one-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regbank_arbiter_rr_picker.sv
// Combinational round-robin selector: first asserted request at or above ptr_i,
// wrapping modulo N. Produces a one-hot-or-zero grant and its encoded index.
module rr_picker
  import regbank_arb_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int PTR_W = ptr_width(DEF_NUM_REQ)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o
);

  int               cand_s;
  logic [PTR_W-1:0] cand_idx_s;
  logic             hit_s;
  logic             found_s;

  // Walk the requests upward from the pointer and keep the first hit.
  always_comb begin
    gnt_o      = '0;
    idx_o      = '0;
    found_s    = 1'b0;
    hit_s      = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int k = 0; k < N; k++) begin
      cand_s            = (int'(ptr_i) + k) % N;
      cand_idx_s        = PTR_W'(cand_s);
      hit_s             = !found_s && req_i[cand_idx_s];
      gnt_o[cand_idx_s] = hit_s;
      idx_o             = hit_s ? cand_idx_s : idx_o;
      found_s           = found_s | hit_s;
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Configuration register bank shared by SPI (port 0) and core (port 1) requesters:
// round-robin grant, bounded lock tenure, one-cycle responses, contention counter.
module regbank_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                              clk_i,
  input  logic                              rstb_i,
  input  logic                              ena_i,
  input  logic [NUM_REQ-1:0]                req_vld_i,
  input  logic [NUM_REQ-1:0]                req_we_i,
  input  logic [NUM_REQ-1:0]                req_lock_i,
  input  logic [NUM_REQ*$clog2(NUM_REGS)-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]          req_wdata_i,
  output logic [NUM_REQ-1:0]                req_gnt_o,
  output logic [NUM_REQ-1:0]                rsp_vld_o,
  output logic [WIDTH-1:0]                  rsp_rdata_o,
  output logic [NUM_REGS*WIDTH-1:0]         config_regs_o,
  output logic [WIDTH-1:0]                  wait_cnt_o
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int PTR_W  = ptr_width(NUM_REQ);
  localparam int CNT_W  = $clog2(LOCK_MAX + 1);

  arb_state_e             state_q, state_d;
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic [NUM_REGS*WIDTH-1:0] regs_q;
  logic [NUM_REQ-1:0]     rsp_vld_q;
  logic [WIDTH-1:0]       rsp_rdata_q;
  logic [WIDTH-1:0]       wait_cnt_q;

  logic [NUM_REQ-1:0]     owner_mask_s, pick_req_s, pick_gnt_s, gnt_s;
  logic [PTR_W-1:0]       pick_ptr_s, pick_idx_s;
  logic                   accept_s, acc_we_s, acc_lock_s, addr_ok_s, contend_s;
  logic [ADDR_W-1:0]      acc_addr_s;
  logic [WIDTH-1:0]       acc_wdata_s, rd_data_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Restrict candidates to the owner while a lock tenure is active.
  always_comb begin
    owner_mask_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_mask_s[i] = (owner_q == PTR_W'(i));
    end
    if (state_q == LOCKED) begin
      pick_req_s = req_vld_i & owner_mask_s;
      pick_ptr_s = owner_q;
    end else begin
      pick_req_s = req_vld_i;
      pick_ptr_s = rr_q;
    end
  end

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i (pick_req_s),
    .ptr_i (pick_ptr_s),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s)
  );

  // Gate the grant and decode the fields of the accepted access.
  always_comb begin
    if (ena_i && rstb_i) begin
      gnt_s = pick_gnt_s;
    end else begin
      gnt_s = '0;
    end
    accept_s    = |gnt_s;
    acc_we_s    = req_we_i[pick_idx_s];
    acc_lock_s  = req_lock_i[pick_idx_s];
    acc_addr_s  = req_addr_i[pick_idx_s*ADDR_W +: ADDR_W];
    acc_wdata_s = req_wdata_i[pick_idx_s*WIDTH +: WIDTH];
    addr_ok_s   = (32'(acc_addr_s) < 32'(NUM_REGS));
    if (addr_ok_s) begin
      rd_data_s = regs_q[acc_addr_s*WIDTH +: WIDTH];
    end else begin
      rd_data_s = '0;
    end
    contend_s = |(req_vld_i & ~gnt_s);
  end

  // Arbitration FSM next-state: round-robin in ARB, owner-only in LOCKED.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (accept_s) begin
      case (state_q)
        ARB: begin
          if (acc_lock_s && (LOCK_MAX > 1)) begin
            state_d    = LOCKED;
            owner_d    = pick_idx_s;
            lock_cnt_d = CNT_W'(1);
          end else begin
            rr_d = next_ptr(pick_idx_s);
          end
        end
        LOCKED: begin
          if (!acc_lock_s || (lock_cnt_q == CNT_W'(LOCK_MAX - 1))) begin
            state_d    = ARB;
            rr_d       = next_ptr(owner_q);
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q    <= ARB;
      rr_q       <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Register storage and the one-cycle response; out-of-range writes are dropped.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      regs_q      <= '0;
      rsp_vld_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_vld_q <= gnt_s;
      if (accept_s) begin
        if (acc_we_s) begin
          if (addr_ok_s) begin
            regs_q[acc_addr_s*WIDTH +: WIDTH] <= acc_wdata_s;
            rsp_rdata_q                       <= acc_wdata_s;
          end else begin
            rsp_rdata_q <= '0;
          end
        end else begin
          rsp_rdata_q <= rd_data_s;
        end
      end else begin
        rsp_rdata_q <= rsp_rdata_q;
      end
    end
  end

  // Saturating count of enabled cycles in which some request waited.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      wait_cnt_q <= '0;
    end else if (ena_i && contend_s && (wait_cnt_q != {WIDTH{1'b1}})) begin
      wait_cnt_q <= wait_cnt_q + WIDTH'(1);
    end else begin
      wait_cnt_q <= wait_cnt_q;
    end
  end

  assign req_gnt_o     = gnt_s;
  assign rsp_vld_o     = rsp_vld_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign config_regs_o = regs_q;
  assign wait_cnt_o    = wait_cnt_q;

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Shares the configuration register bank between several requesters (port 0: SPI serial front end; port 1: on-chip core) over a valid/grant handshake. Owns the bank storage and exposes it flat as `config_regs`. Provides round-robin arbitration, a bounded lock for atomic multi-register sequences, one-cycle read/write responses and a saturating contention counter for debug.

## Interface
- `NUM_REGS`, 8, number of WIDTH-bit registers; `ADDR_W = $clog2(NUM_REGS)` (derived localparam)
- `WIDTH`, 8, register width
- `NUM_REQ`, 2, number of requesters (index 0 = SPI, 1 = core)
- `LOCK_MAX`, 4, max accesses per lock tenure, ≥1
- `clk`  in  1  single clock
- `rstb`  in  1  asynchronous, active-low reset
- `ena`  in  1  block enable; low freezes arbitration, writes and counter
- `req_vld`  in  NUM_REQ  access request per port
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_lock`  in  NUM_REQ  keep ownership after this access
- `req_addr`  in  NUM_REQ*ADDR_W  port i at `[i*ADDR_W +: ADDR_W]`
- `req_wdata`  in  NUM_REQ*WIDTH  port i at `[i*WIDTH +: WIDTH]`
- `req_gnt`  out  NUM_REQ  combinational grant, one-hot-or-zero
- `rsp_vld`  out  NUM_REQ  one-cycle response pulse to the accepted port
- `rsp_rdata`  out  WIDTH  response data, shared by all ports
- `config_regs`  out  NUM_REGS*WIDTH  register k at `[k*WIDTH +: WIDTH]`
- `wait_cnt`  out  WIDTH  saturating contention counter

## Operation
- Accept = `req_vld[i] && req_gnt[i]`. Requester holds vld/we/lock/addr/wdata stable until granted. Deasserting vld before grant is allowed and drops the request.
- `req_gnt` is zero whenever `ena`=0 or `rstb`=0.
- FSM states ARB and LOCKED.
- ARB: grant the first requesting port searching upward from `rr_ptr` (mod NUM_REQ).
  - Accept without lock: `rr_ptr <= i+1` mod NUM_REQ.
  - Accept with lock: go to LOCKED, `owner <= i`, `lock_cnt <= 1`.
- LOCKED: only `owner` can be granted; other ports wait.
  - Owner accept with lock=0, or accept making `lock_cnt == LOCK_MAX`: return to ARB, `rr_ptr <= owner+1`.
  - Otherwise `lock_cnt` increments.
  - Owner idle (vld=0) holds LOCKED indefinitely.
- LOCK_MAX=1 means a locked access never enters LOCKED.
- Write accept: `mem[addr] <= wdata`; next cycle `rsp_vld[i]`=1, `rsp_rdata` = written value.
- Read accept: next cycle `rsp_vld[i]`=1, `rsp_rdata` = `mem[addr]` as of the accept cycle.
- Address ≥ NUM_REGS (non-power-of-2 NUM_REGS): write ignored, read returns 0, response still issued.
- `rsp_rdata` holds its last value when `rsp_vld` is 0.
- `wait_cnt` increments by 1 in each `ena`=1 cycle where some port has vld=1 and gnt=0. Saturates at 2^WIDTH-1. Cleared only by reset.
- `ena` falling with a response pending: the response is still delivered next cycle. State, `rr_ptr`, `lock_cnt` and `wait_cnt` hold.
- Reset (asynchronous, any time): mem=0, `config_regs`=0, `rsp_vld`=0, `rsp_rdata`=0, `wait_cnt`=0, state=ARB, `rr_ptr`=0, `lock_cnt`=0. An in-flight response is discarded.

## Timing
- Grant is combinational in the request cycle; throughput is one access per cycle, back-to-back.
- Response latency is 1 cycle after accept.
- A write is visible on `config_regs` and to reads accepted 1 cycle after the write's accept.
- `config_regs` and `rsp_*` are registered outputs; `req_gnt` is the only combinational output.
- Simultaneous requests: exactly one is granted per cycle; the loser counts toward `wait_cnt` and keeps waiting.
- Lock transition takes effect on the cycle after the accepting edge.

## Structure
- Package `regbank_arb_pkg`: `arb_state_e` {ARB, LOCKED} and default parameter constants.
- Sub-module `rr_picker`: combinational round-robin selector. Inputs are the request vector and pointer; outputs are the one-hot grant and the encoded index. It is instantiated once and masked to `owner` in LOCKED.
- Storage, FSM, counter and response registers live in the top module.

## Test plan
- Reset then single writes: port 0 writes 0xA5 to addr 3 → `req_gnt[0]` same cycle, `rsp_vld[0]` next cycle with 0xA5, `config_regs[31:24]`=0xA5. After `rstb` pulse, all outputs are 0.
- Contention: both ports request reads every cycle from reset → grants alternate 0,1,0,1. `wait_cnt` = 1 after the first cycle and +1 per cycle. Each `rsp_vld` follows its own grant by 1 cycle.
- Lock: port 1 issues 3 locked writes (0x11, 0x22, 0x33 to addrs 0–2) then an unlocked read while port 0 requests continuously → port 0 is granted only after port 1's fourth access. Then port 0 is next in turn.
- Lock cap: port 1 keeps lock=1 for 6 accesses, LOCK_MAX=4 → forced to ARB after the 4th; port 0 is granted on the next cycle.
- Saturation/enable: WIDTH=8, hold contention for 300 cycles → `wait_cnt`=0xFF. Drop `ena` mid-run → no grants, no writes, counter and state frozen; the pending response is still delivered.
- Read-after-write: port 0 writes 0x5A to addr 7, port 1 reads addr 7 next cycle → `rsp_rdata`=0x5A.
